// File: rtl/dmem_resp.sv
// Memory end of the DREQ/nDWAIT data bus: stores 39-bit codewords verbatim, inserts
// programmable wait states, flags illegal accesses and can corrupt words on command.
module dmem_resp #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          DREQ,
  input  logic [31:0]   DADDR,
  input  logic          DRW,
  input  logic [38:0]   DWDATA,
  output logic [38:0]   DRDATA,
  output logic          nDWAIT,
  output logic          DFAULT,
  input  logic [3:0]    WAIT_CFG,
  input  logic          INJ_EN,
  input  logic [AW-1:0] INJ_ADDR,
  input  logic [38:0]   INJ_MASK,
  output logic          INJ_DROP
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [38:0] mem_reg [DEPTH];

  logic [AW-1:0] word_idx;
  logic          illegal;
  logic          done;
  logic          wr_fire;
  logic          inj_collide;

  assign word_idx = DADDR[AW+1:2];
  assign illegal  = (DADDR[1:0] != 2'b00) || (|DADDR[31:AW+2]);

  // Completion is gated by nRST so outputs hold their reset values while reset is asserted.
  assign done = nRST && DREQ &&
                ((state_reg == IDLE) ? (WAIT_CFG == 4'd0) : (cnt_reg == 4'd0));

  assign wr_fire     = done && !illegal && DRW;
  assign inj_collide = INJ_EN && wr_fire && (INJ_ADDR == word_idx);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; a request dropped while BUSY simply abandons the access.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (DREQ && (WAIT_CFG != 4'd0)) begin
          state_next = BUSY;
          cnt_next   = WAIT_CFG - 4'd1;
        end
      end
      BUSY: begin
        if (!DREQ || (cnt_reg == 4'd0)) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    nDWAIT = 1'b1;
    DFAULT = 1'b0;
    DRDATA = '0;
    if (nRST) begin
      if (state_reg == BUSY)
        nDWAIT = (cnt_reg == 4'd0);
      else
        nDWAIT = !(DREQ && (WAIT_CFG != 4'd0));
    end
    if (done) begin
      DFAULT = illegal;
      if (!illegal && !DRW)
        DRDATA = mem_reg[word_idx];
    end
  end

  // A completing write to the same word takes precedence over an injection.
  always_ff @(posedge CLK) begin
    if (wr_fire)
      mem_reg[word_idx] <= DWDATA;
    if (INJ_EN && !inj_collide)
      mem_reg[INJ_ADDR] <= mem_reg[INJ_ADDR] ^ INJ_MASK;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      INJ_DROP <= 1'b0;
    else
      INJ_DROP <= inj_collide;
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized scoreboard bench for dmem_resp: stimulus pushes expected completions,
// an independent monitor pops and compares whenever the responder completes.
module tb_dmem_resp;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          DREQ;
  logic [31:0]   DADDR;
  logic          DRW;
  logic [38:0]   DWDATA;
  logic [38:0]   DRDATA;
  logic          nDWAIT;
  logic          DFAULT;
  logic [3:0]    WAIT_CFG;
  logic          INJ_EN;
  logic [AW-1:0] INJ_ADDR;
  logic [38:0]   INJ_MASK;
  logic          INJ_DROP;

  dmem_resp #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .DREQ(DREQ), .DADDR(DADDR), .DRW(DRW),
    .DWDATA(DWDATA), .DRDATA(DRDATA), .nDWAIT(nDWAIT), .DFAULT(DFAULT),
    .WAIT_CFG(WAIT_CFG), .INJ_EN(INJ_EN), .INJ_ADDR(INJ_ADDR),
    .INJ_MASK(INJ_MASK), .INJ_DROP(INJ_DROP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [38:0] data;
    logic        fault;
    int          stalls;
    int          id;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [38:0] model [DEPTH];
  int checks = 0, errors = 0;
  int exp_drops = 0, seen_drops = 0, txn_id = 0, stalls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
  endtask

  function automatic bit is_illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [38:0] rand39();
    return 39'({$urandom(), $urandom()});
  endfunction

  // Monitor: one line per completed transaction
  always @(negedge CLK) begin
    if (!nRST) begin
      stalls = 0;
    end else if (DREQ) begin
      if (!nDWAIT) begin
        stalls++;
      end else begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got completion expected none (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          check("rdata", 64'(DRDATA), 64'(mon_e.data));
          check("fault", 64'(DFAULT), 64'(mon_e.fault));
          check("stalls", 64'(stalls), 64'(mon_e.stalls));
          $display("txn %0d: addr=%h rw=%0d stalls=%0d fault=%0d rdata=%h",
                   mon_e.id, DADDR, DRW, stalls, DFAULT, DRDATA);
        end
        stalls = 0;
      end
    end else begin
      check("idle_outputs", {24'd0, nDWAIT, DFAULT, DRDATA}, {24'd0, 1'b1, 1'b0, 39'd0});
    end
    if (nRST && INJ_DROP) seen_drops++;
  end

  // Issue one access; returns just after the completion edge with DREQ still high.
  task automatic txn(input bit rw, input logic [31:0] a, input logic [38:0] wd,
                     input logic [3:0] wc, input bit inj,
                     input logic [AW-1:0] ia, input logic [38:0] im);
    exp_t e;
    bit   bad;
    int   idx;
    bit   fin;
    bad = is_illegal(a);
    idx = int'((a / 4) % DEPTH);
    // With wait states the injection lands at the first edge, before completion.
    if (inj && wc != 0) model[ia] = model[ia] ^ im;
    e.data   = (!rw && !bad) ? model[idx] : 39'd0;
    e.fault  = bad;
    e.stalls = int'(wc);
    e.id     = txn_id++;
    if (rw && !bad) model[idx] = wd;
    if (inj && wc == 0) begin
      if (rw && !bad && idx == int'(ia)) exp_drops++;
      else model[ia] = model[ia] ^ im;
    end
    sb.push_back(e);
    DREQ = 1'b1; DRW = rw; DADDR = a; DWDATA = wd; WAIT_CFG = wc;
    INJ_EN = inj; INJ_ADDR = ia; INJ_MASK = im;
    fin = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge CLK);
      if (nDWAIT) fin = 1'b1;
      @(posedge CLK);
      #1;
      INJ_EN = 1'b0;
      if (!fin) WAIT_CFG = 4'($urandom());
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no completion expected one within 40 cycles (txn %0d)", e.id);
      summary();
      $finish;
    end
  endtask

  task automatic idle(input int n);
    DREQ = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic inject_idle(input logic [AW-1:0] ia, input logic [38:0] im);
    DREQ = 1'b0; INJ_EN = 1'b1; INJ_ADDR = ia; INJ_MASK = im;
    model[ia] = model[ia] ^ im;
    @(posedge CLK);
    #1;
    INJ_EN = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; DREQ = 1'b1; DADDR = 32'h10; DRW = 1'b0; DWDATA = '0;
    WAIT_CFG = 4'd0; INJ_EN = 1'b0; INJ_ADDR = '0; INJ_MASK = '0;
    repeat (2) @(negedge CLK);
    check("reset_ndwait", 64'(nDWAIT), 64'd1);
    check("reset_dfault", 64'(DFAULT), 64'd0);
    check("reset_drdata", 64'(DRDATA), 64'd0);
    check("reset_injdrop", 64'(INJ_DROP), 64'd0);
    @(posedge CLK);
    #1;
    DREQ = 1'b0;
    nRST = 1'b1;
    idle(1);

    // Fill every word so all later reads have a known reference value.
    for (int i = 0; i < DEPTH; i++)
      txn(1'b1, 32'(i * 4), rand39(), 4'd0, 1'b0, '0, '0);
    idle(1);

    // Zero-wait write then back-to-back read
    txn(1'b1, 32'h10, 39'h1_2345_6789, 4'd0, 1'b0, '0, '0);
    txn(1'b0, 32'h10, '0, 4'd0, 1'b0, '0, '0);
    idle(1);
    txn(1'b0, 32'h10, '0, 4'd3, 1'b0, '0, '0);
    idle(1);

    // Out-of-range read, misaligned write, then the target word must be intact
    txn(1'b0, 32'h1000, '0, 4'd0, 1'b0, '0, '0);
    txn(1'b1, 32'h12, rand39(), 4'd0, 1'b0, '0, '0);
    txn(1'b0, 32'h10, '0, 4'd0, 1'b0, '0, '0);
    idle(1);

    inject_idle(10'd4, 39'h0_0000_0001);
    txn(1'b0, 32'h10, '0, 4'd0, 1'b0, '0, '0);
    idle(1);

    // Injection colliding with a completing write: write wins, drop pulses once
    txn(1'b1, 32'h10, 39'h0_AAAA_5555, 4'd0, 1'b1, 10'd4, 39'h7F_0000_00FF);
    DREQ = 1'b0;
    @(negedge CLK);
    check("drop_pulse", 64'(INJ_DROP), 64'd1);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("drop_cleared", 64'(INJ_DROP), 64'd0);
    @(posedge CLK);
    #1;
    txn(1'b0, 32'h10, '0, 4'd0, 1'b0, '0, '0);
    idle(1);

    // Reset in the third stall cycle abandons the write
    DREQ = 1'b1; DRW = 1'b1; DADDR = 32'h20; DWDATA = 39'h0_DEAD_BEEF; WAIT_CFG = 4'd5;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("abort_stall", 64'(nDWAIT), 64'd0);
    nRST = 1'b0;
    #1;
    check("abort_ndwait", 64'(nDWAIT), 64'd1);
    check("abort_dfault", 64'(DFAULT), 64'd0);
    check("abort_drdata", 64'(DRDATA), 64'd0);
    DRW = 1'b0; WAIT_CFG = 4'd0;
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    txn(1'b0, 32'h20, '0, 4'd0, 1'b0, '0, '0);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit            rw;
      int            sel;
      int            idx;
      logic [31:0]   a;
      logic [3:0]    wc;
      bit            inj;
      logic [AW-1:0] ia;
      rw  = 1'($urandom());
      sel = int'($urandom_range(0, 7));
      idx = int'($urandom_range(0, DEPTH - 1));
      a   = 32'(idx * 4);
      if (sel == 6) a = a | 32'($urandom_range(1, 3));
      if (sel == 7) a = ($urandom() % 2 == 0) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 4096))
                                               : ($urandom() | 32'h8000_0000);
      wc  = ($urandom() % 4 == 0) ? 4'($urandom()) : 4'($urandom_range(0, 2));
      inj = ($urandom() % 5 == 0);
      ia  = ($urandom() % 2 == 0) ? AW'(idx) : AW'($urandom());
      txn(rw, a, rand39(), wc, inj, ia, rand39());
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    check("drop_count", 64'(seen_drops), 64'(exp_drops));
    check("queue_empty", 64'(sb.size()), 64'd0);
    summary();
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the fault-tolerant core's 39-bit ECC data bus. It is the memory end of the `DREQ`/`nDWAIT` protocol that the core-side DMEM shell initiates. It stores 39-bit codewords verbatim, with no ECC of its own, and inserts a runtime-programmable number of wait states. It flags illegal accesses on `DFAULT` and can corrupt stored words on command, so the shell's SEC/DED and rewrite paths can be exercised in system simulation and on FPGA.

## Interface
- `DEPTH`, default 1024: number of 39-bit words. Must be a power of two, at least 2.
- `CLK`  in  1  single clock. All state changes on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `DREQ`  in  1  request. Held high, with all request fields stable, until the completion cycle.
- `DADDR`  in  32  byte address. Word index is `DADDR[log2(DEPTH)+1:2]`.
- `DRW`  in  1  0 = read, 1 = write.
- `DWDATA`  in  39  write codeword.
- `DRDATA`  out  39  read codeword. Valid only in a read completion cycle; 0 otherwise.
- `nDWAIT`  out  1  0 = stall. A cycle with `DREQ`=1 and `nDWAIT`=1 is the completion cycle.
- `DFAULT`  out  1  access error. Valid in the completion cycle only.
- `WAIT_CFG`  in  4  wait states per access, 0–15. Sampled when a request starts.
- `INJ_EN`  in  1  single-cycle pulse: corrupt one stored word.
- `INJ_ADDR`  in  log2(DEPTH)  word index to corrupt.
- `INJ_MASK`  in  39  XOR mask applied to the stored word.
- `INJ_DROP`  out  1  registered; 1 for one cycle when an injection was discarded.

## Operation
- Storage is a DEPTH×39 array with combinational read and synchronous write. The array is not cleared by reset.
- FSM has two states: IDLE and BUSY, with a 4-bit down-counter `cnt`.
- **IDLE, `DREQ`=0:** `nDWAIT`=1, `DRDATA`=0, `DFAULT`=0.
- **IDLE, `DREQ`=1, `WAIT_CFG`=0:** the current cycle is the completion cycle.
- **IDLE, `DREQ`=1, `WAIT_CFG`=N>0:**
  - Drive `nDWAIT`=0.
  - Load `cnt` with N−1, go to BUSY.
- **BUSY:**
  - If `cnt`≠0: `nDWAIT`=0 and `cnt` decrements.
  - If `cnt`=0: the current cycle is the completion cycle. Drive `nDWAIT`=0 when `cnt`≠0 and 1 when `cnt`=0.
  - Go to IDLE at the end of the completion cycle.
- **Completion cycle:**
  - `nDWAIT`=1.
  - Illegal access means `DADDR[1:0]`≠0 or `DADDR` ≥ 4·DEPTH. In that case `DFAULT`=1, `DRDATA`=0, and no write occurs.
  - Legal read: `DRDATA` = array[index].
  - Legal write: array[index] ← `DWDATA` at the closing edge.
- **Back-to-back requests:** a request still present in the cycle after a completion is treated as a new request from IDLE. There are no bubbles beyond `WAIT_CFG`.
- **`WAIT_CFG` changes:** a change mid-access does not affect the access in flight.
- **Injection:**
  - On `INJ_EN`=1: array[`INJ_ADDR`] ← array[`INJ_ADDR`] XOR `INJ_MASK` at the edge.
  - If a legal write completes to the same index in the same cycle, the write wins, the injection is discarded, and `INJ_DROP` pulses 1 on the next cycle.
  - A read completing in the same cycle returns the pre-injection value.
- **`DREQ` drops while BUSY:** this is a protocol violation. The responder returns to IDLE on the next edge with no write.

## Timing
- **Reset values:**
  - `nDWAIT`=1, `DRDATA`=0, `DFAULT`=0, `INJ_DROP`=0.
  - FSM in IDLE, `cnt`=0.
- **Reset mid-access:** `nRST` low in BUSY forces IDLE immediately; the pending write is never performed. Assertion is asynchronous; deassertion is sampled at the next `CLK` edge.
- **Latency:** an access completes WAIT_CFG+1 cycles after the first `DREQ` cycle, inclusive. `nDWAIT` is low for exactly WAIT_CFG cycles.
- **Combinational paths:** `nDWAIT`, `DRDATA` and `DFAULT` are decoded from FSM state, `cnt` and the request inputs, so they can respond in the same cycle as the request.
- **Write visibility:** a written value is readable by the next request, including a zero-wait request issued in the following cycle.

## Test plan
- **Reset:** assert `nRST`=0 with `DREQ`=1 → `nDWAIT`=1, `DFAULT`=0, `DRDATA`=0, `INJ_DROP`=0.
- **Zero-wait write then read:** `WAIT_CFG`=0; write 0x1_2345_6789 to `DADDR`=0x10, then read 0x10 next cycle.
  - Both complete in one cycle each, with `nDWAIT` never 0.
  - Read returns 0x1_2345_6789.
- **Wait states:** `WAIT_CFG`=3; read 0x10 → `nDWAIT`=0,0,0 then 1. Change `WAIT_CFG` to 7 mid-access → still 3 stalls.
- **Faults:** `DEPTH`=1024.
  - Read `DADDR`=0x1000 → `DFAULT`=1, `DRDATA`=0.
  - Write `DADDR`=0x12 → `DFAULT`=1; a subsequent read of 0x10 is unchanged.
- **Injection:**
  - `INJ_EN` with `INJ_ADDR`=4, `INJ_MASK`=0x0_0000_0001 → read 0x10 returns 0x1_2345_6788.
  - Injection to index 4 coincident with a write of 0x0_AAAA_5555 to 0x10 → read returns 0x0_AAAA_5555 and `INJ_DROP` pulses once.
- **Reset mid-access:** `WAIT_CFG`=5; write 0x0_DEAD_BEEF to 0x20, pulse `nRST` low in the 3rd stall cycle → read of 0x20 (new request after reset) returns the old value and `nDWAIT`=1 right after reset.
